// File: rtl/counter_pkg.sv
// Shared defaults and FSM state codes for the round-robin counter arbiter.
package counter_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int CNT_W_DEF = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/counter_arb_ctrl_if.sv
// Requester-side bundle: request/length in, grant/status/pulses out.
interface counter_arb_ctrl_if
  import counter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       abort;
  logic [CNT_W-1:0]      po_cnt;

  modport master (
    output req, req_len,
    input  gnt, busy, done, abort, po_cnt
  );

  modport slave (
    input  req, req_len,
    output gnt, busy, done, abort, po_cnt
  );

endinterface

// File: rtl/counter_arb_ctrl_rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arb_ctrl.sv
// Shared run-length counter granted round-robin; a run lasts len+1 cycles and
// ends with a done pulse, or an abort pulse if the owner drops its request.
module counter_arb_ctrl
  import counter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  counter_arb_ctrl_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [0:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gidx;
  logic [CNT_W-1:0] len_q;
  logic [NREQ-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic [CNT_W-1:0] sel_len;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (arb_gnt),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) sel_len = bus.req_len[i*CNT_W +: CNT_W];
    end
  end

  assign bus.busy = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= IW'(NREQ - 1);
      gidx       <= '0;
      len_q      <= '0;
      bus.gnt    <= '0;
      bus.done   <= '0;
      bus.abort  <= '0;
      bus.po_cnt <= '0;
    end else begin
      bus.done  <= '0;
      bus.abort <= '0;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            bus.gnt    <= arb_gnt;
            gidx       <= arb_idx;
            ptr        <= arb_idx;
            len_q      <= sel_len;
            bus.po_cnt <= '0;
            state      <= ST_RUN;
          end
        end
        default: begin
          // A dropped request outranks reaching the terminal count.
          if (!bus.req[gidx]) begin
            bus.abort  <= bus.gnt;
            bus.gnt    <= '0;
            bus.po_cnt <= '0;
            state      <= ST_IDLE;
          end else if (bus.po_cnt == len_q) begin
            bus.done   <= bus.gnt;
            bus.gnt    <= '0;
            bus.po_cnt <= '0;
            state      <= ST_IDLE;
          end else begin
            bus.po_cnt <= bus.po_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/counter_arb_ctrl.md
COUNTER_ARB_CTRL -- requirements
Module: counter_arb_ctrl

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the counter.
REQ-002 Parameter CNT_W, default 4, counter and run-length width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester request; held high until done or abort.
REQ-006 req_len  input  NREQ*CNT_W  per-requester terminal count; slice i = bits [i*CNT_W +: CNT_W].
REQ-007 gnt  output  NREQ  one-hot grant; all zero when idle.
REQ-008 busy  output  1  high while a run is in progress (state RUN).
REQ-009 done  output  NREQ  one-cycle pulse to the requester whose run completed.
REQ-010 abort  output  NREQ  one-cycle pulse to the requester whose run was cancelled.
REQ-011 po_cnt  output  CNT_W  shared counter value.

Function
REQ-012 States SHALL be IDLE and RUN only.
REQ-013 IDLE with req != 0: the next edge SHALL select one requester round-robin, set gnt one-hot, latch its req_len slice, clear po_cnt to 0, enter RUN.
REQ-014 Round-robin search SHALL start at index (ptr+1) mod NREQ and wrap; ptr SHALL update to the granted index at grant.
REQ-015 IDLE with req == 0: state, gnt and po_cnt SHALL hold (gnt=0, po_cnt=0).
REQ-016 RUN with po_cnt != latched len and req[g] high: po_cnt SHALL increment by 1 per cycle.
REQ-017 RUN with po_cnt == latched len and req[g] high: the next edge SHALL clear gnt, pulse done[g] for exactly one cycle, clear po_cnt, enter IDLE.
REQ-018 Grant duration SHALL be len+1 cycles; len=0 gives one cycle at po_cnt=0; len=2^CNT_W-1 counts 0..max with no wrap.
REQ-019 RUN with req[g] low (any po_cnt): the next edge SHALL clear gnt, pulse abort[g] for one cycle, clear po_cnt, enter IDLE; done SHALL not assert.
REQ-020 Terminal and req[g] drop in the same cycle: abort SHALL win; done SHALL not assert.
REQ-021 req_len changes after grant SHALL be ignored until the next grant.
REQ-022 Requests arriving during RUN SHALL wait; no preemption.
REQ-023 Minimum gap between grants SHALL be one IDLE cycle, concurrent with the done/abort pulse cycle.
REQ-024 busy SHALL be high exactly when state == RUN; at most one bit of gnt, done, abort SHALL be high in any cycle.

Reset
REQ-025 rst high at an edge SHALL force state IDLE, gnt=0, done=0, abort=0, busy=0, po_cnt=0, and ptr=NREQ-1, so requester 0 has first priority; this applies mid-run with no done or abort pulse.
REQ-026 Arbitration SHALL resume on the first edge after rst deasserts.

Structure
REQ-027 Package counter_pkg SHALL hold the NREQ and CNT_W defaults and the state enumeration.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and ptr; outputs one-hot grant and index), purely combinational.
REQ-029 The counter, length latch and FSM SHALL reside in counter_arb_ctrl.

Verification
REQ-030 After reset, req=4'b0001, len0=3 -> gnt=0001 for 4 cycles, po_cnt 0,1,2,3, then done[0] pulse, po_cnt=0.
REQ-031 req=4'b1111 held, all len=0 -> grants 0,1,2,3,0 in order, each lasting 1 cycle, with 1 IDLE cycle between.
REQ-032 Grant to 2 with len2=15, req[2] dropped when po_cnt=5 -> abort[2] pulse next cycle, no done, po_cnt=0.
REQ-033 len1=15 -> po_cnt reaches 15 with no wrap, then done[1]; changing len1 mid-run has no effect.
REQ-034 rst asserted when po_cnt=2 -> next cycle all outputs zero, no pulses; next grant goes to the lowest requesting index.
REQ-035 Terminal and req drop in the same cycle -> abort only.
